// File: rtl/trng_fetch.sv
// trng_fetch: requesting client for a 256-bit TRNG word store.
// On req it kicks a TRNG generation run, waits for completion, reads the
// eight 32-bit words back (word 0 least significant), and applies rejection
// sampling so every delivered value is uniform in [0, P-1].
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   req           request one value (sampled only in IDLE)
//   busy          high whenever the FSM is not IDLE
//   valid         one-cycle pulse, value carries a freshly accepted result
//   value         last accepted value, held until the next accept
//   err           one-cycle pulse, request aborted (retry limit or timeout)
//   retries       rejected bursts for the current/last request, saturating
//   trng_en       start pulse to the TRNG
//   trng_rd_en    TRNG word read strobe
//   trng_addr     TRNG word index
//   trng_out      TRNG read data, valid the cycle after trng_rd_en
//   trng_rdy      TRNG idle with the word store valid
module trng_fetch #(
  parameter logic [255:0] P         = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff,
  parameter int           MAX_RETRY = 8,
  parameter int           TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  output logic         busy,
  output logic         valid,
  output logic [255:0] value,
  output logic         err,
  output logic [3:0]   retries,
  output logic         trng_en,
  output logic         trng_rd_en,
  output logic [2:0]   trng_addr,
  input  logic [31:0]  trng_out,
  input  logic         trng_rdy
);

  localparam int              TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LIM     = TW'(TIMEOUT);
  localparam logic [31:0]     MAX_RETRY_U = 32'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, KICK, WAIT, READ, CHECK} state_t;

  state_t         state_q, state_d;
  logic [3:0]     rd_cnt_q, rd_cnt_d;
  logic           cap_vld_q, cap_vld_d;
  logic [2:0]     cap_addr_q, cap_addr_d;
  logic [255:0]   asm_q, asm_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [255:0]   value_q, value_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [3:0]     retries_q, retries_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  // TRNG-side strobes are decoded from state so they can never outlive a
  // reset or violate the same-cycle rdy qualification on trng_en.
  assign busy       = (state_q != IDLE);
  assign trng_en    = (state_q == KICK) && trng_rdy;
  assign trng_rd_en = (state_q == READ) && !rd_cnt_q[3];
  assign trng_addr  = trng_rd_en ? rd_cnt_q[2:0] : 3'd0;
  assign valid      = valid_q;
  assign err        = err_q;
  assign value      = value_q;
  assign retries    = retries_q;

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    cap_vld_d  = trng_rd_en;
    cap_addr_d = trng_addr;
    asm_d      = asm_q;
    tmo_d      = tmo_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    retries_d  = retries_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          retries_d = 4'd0;
          state_d   = KICK;
        end
      end
      KICK: begin
        if (trng_rdy) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // tmo_q == 0 marks the first WAIT cycle, where rdy is still stale.
        if ((tmo_q != '0) && trng_rdy) begin
          rd_cnt_d = 4'd0;
          asm_d    = '0;
          state_d  = READ;
        end else if (tmo_d == TMO_LIM) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      READ: begin
        if (!trng_rdy) begin
          // TRNG restarted under us: the words in flight are unreliable.
          asm_d     = '0;
          retries_d = sat_inc(retries_q);
          state_d   = KICK;
        end else begin
          if (!rd_cnt_q[3]) rd_cnt_d = rd_cnt_q + 4'd1;
          if (cap_vld_q) begin
            asm_d[{cap_addr_q, 5'd0} +: 32] = trng_out;
            if (cap_addr_q == 3'd7) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (asm_q < P) begin
          value_d = asm_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          retries_d = sat_inc(retries_q);
          if ({28'd0, retries_d} > MAX_RETRY_U) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = KICK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= 4'd0;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= 3'd0;
      asm_q      <= '0;
      tmo_q      <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      retries_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      cap_vld_q  <= cap_vld_d;
      cap_addr_q <= cap_addr_d;
      asm_q      <= asm_d;
      tmo_q      <= tmo_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      retries_q  <= retries_d;
    end
  end

endmodule

// File: tb/tb_trng_fetch.sv
// Bench for trng_fetch: dut_a (MAX_RETRY=3) runs the data-path scenarios
// against a TRNG model that holds rdy low for 20 cycles after each start;
// dut_b (TIMEOUT=16) runs against a TRNG that never completes.
module tb_trng_fetch;

  localparam logic [255:0] P = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

  typedef struct {
    logic         is_err;
    logic [255:0] value;
    logic [3:0]   retries;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a side
  logic         req_a = 1'b0;
  logic         busy_a, valid_a, err_a, en_a, rd_en_a;
  logic [255:0] value_a;
  logic [3:0]   retries_a;
  logic [2:0]   addr_a;
  logic [31:0]  out_a = 32'd0;
  logic         rdy_a = 1'b1;

  // dut_b side
  logic         req_b = 1'b0;
  logic         busy_b, valid_b, err_b, en_b, rd_en_b;
  logic [255:0] value_b;
  logic [3:0]   retries_b;
  logic [2:0]   addr_b;
  logic [31:0]  out_b = 32'd0;
  logic         rdy_b = 1'b1;

  trng_fetch #(.MAX_RETRY(3)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .busy(busy_a), .valid(valid_a),
    .value(value_a), .err(err_a), .retries(retries_a), .trng_en(en_a),
    .trng_rd_en(rd_en_a), .trng_addr(addr_a), .trng_out(out_a), .trng_rdy(rdy_a)
  );

  trng_fetch #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .busy(busy_b), .valid(valid_b),
    .value(value_b), .err(err_b), .retries(retries_b), .trng_en(en_b),
    .trng_rd_en(rd_en_b), .trng_addr(addr_b), .trng_out(out_b), .trng_rdy(rdy_b)
  );

  // TRNG model A: bursts come from a queue (all-ones when empty)
  logic [255:0] bursts_a[$];
  logic [255:0] burst_a = '0;
  int           low_a = 0;
  int           en_cnt_a = 0, valid_cnt_a = 0, viol = 0;
  logic         prev_en_a = 1'b0, prev_en_b = 1'b0;
  int           en_cnt_b = 0, rd_cnt_b = 0;

  always @(posedge clk) begin
    if (en_a) begin
      rdy_a    <= 1'b0;
      low_a    <= 19;
      en_cnt_a <= en_cnt_a + 1;
      if (bursts_a.size() > 0) burst_a <= bursts_a.pop_front();
      else                     burst_a <= '1;
    end else if (!rdy_a) begin
      if (low_a == 0) rdy_a <= 1'b1;
      else            low_a <= low_a - 1;
    end
    if (rd_en_a) out_a <= burst_a[{addr_a, 5'd0} +: 32];
    if (valid_a) valid_cnt_a <= valid_cnt_a + 1;
    prev_en_a <= en_a;
    prev_en_b <= en_b;
    if ((en_a && (!rdy_a || prev_en_a || rd_en_a)) ||
        (en_b && (!rdy_b || prev_en_b || rd_en_b)) ||
        (valid_a && err_a))
      viol <= viol + 1;
  end

  // TRNG model B: drops rdy on start and never raises it again
  always @(posedge clk) begin
    if (en_b) begin
      rdy_b    <= 1'b0;
      en_cnt_b <= en_cnt_b + 1;
    end
    if (rd_en_b) rd_cnt_b <= rd_cnt_b + 1;
  end

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_a[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge; issues one request and checks its outcome
  // against the scoreboard head.
  task automatic run_a(input string tag, input int budget, output int lat, output int en_pulses);
    int   e0;
    logic got;
    exp_t e;
    e0    = en_cnt_a;
    req_a = 1'b1;
    lat   = 0;
    got   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      req_a = 1'b0;
      lat++;
      if (valid_a || err_a) begin
        got = 1'b1;
        break;
      end
    end
    en_pulses = en_cnt_a - e0;
    chk({tag, " result seen"}, got, 1'b1);
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      chk({tag, " valid"}, valid_a, !e.is_err);
      chk({tag, " err"}, err_a, e.is_err);
      chk({tag, " value"}, value_a, e.value);
      chk({tag, " retries"}, retries_a, e.retries);
      chk({tag, " busy low"}, busy_a, 1'b0);
    end
    @(posedge clk); #1;
    chk({tag, " pulse ends"}, {valid_a, err_a}, 2'b00);
  endtask

  int   lat, enp, v0, n;
  logic hit;
  logic [255:0] x;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst busy", busy_a, 1'b0);
    chk("rst valid", valid_a, 1'b0);
    chk("rst err", err_a, 1'b0);
    chk("rst value", value_a, 256'd0);
    chk("rst retries", retries_a, 4'd0);
    chk("rst trng_en", en_a, 1'b0);
    chk("rst rd_en", rd_en_a, 1'b0);
    chk("rst addr", addr_a, 3'd0);
    chk("rst busy_b", busy_b, 1'b0);

    // value 1, best-case latency
    bursts_a.push_back(256'd1);
    sb_a.push_back('{1'b0, 256'd1, 4'd0});
    run_a("t1", 200, lat, enp);
    chk("t1 latency", lat, 33);
    chk("t1 en pulses", enp, 1);

    // all-ones rejected, then top word only
    x = 256'd0;
    x[255:224] = 32'h12345678;
    bursts_a.push_back('1);
    bursts_a.push_back(x);
    sb_a.push_back('{1'b0, x, 4'd1});
    run_a("t2", 300, lat, enp);
    chk("t2 en pulses", enp, 2);

    // P rejected, P-1 accepted
    bursts_a.push_back(P);
    bursts_a.push_back(P - 256'd1);
    sb_a.push_back('{1'b0, P - 256'd1, 4'd1});
    run_a("t3", 300, lat, enp);
    chk("t3 en pulses", enp, 2);

    // retry limit: empty queue yields all-ones forever
    v0 = valid_cnt_a;
    sb_a.push_back('{1'b1, P - 256'd1, 4'd4});
    run_a("t4", 600, lat, enp);
    chk("t4 en pulses", enp, 4);
    chk("t4 no valid", valid_cnt_a - v0, 0);
    repeat (5) @(posedge clk);
    #1 chk("t4 retries stable", retries_a, 4'd4);

    // timeout on dut_b
    req_b = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_b = 1'b0;
      if (en_b) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t5 en seen", hit, 1'b1);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (err_b || valid_b) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t5 err seen", hit, 1'b1);
    chk("t5 en-to-err cycles", n, 17);
    chk("t5 err", err_b, 1'b1);
    chk("t5 valid", valid_b, 1'b0);
    chk("t5 busy", busy_b, 1'b0);
    chk("t5 rd strobes", rd_cnt_b, 0);
    chk("t5 en pulses", en_cnt_b, 1);

    // reset during the 4th READ cycle, then a fresh request
    bursts_a.push_back(256'hdead_beef);
    req_a = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      req_a = 1'b0;
      if (rd_en_a && addr_a == 3'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t6 read reached", hit, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6 busy", busy_a, 1'b0);
    chk("t6 valid", valid_a, 1'b0);
    chk("t6 err", err_a, 1'b0);
    chk("t6 value", value_a, 256'd0);
    chk("t6 retries", retries_a, 4'd0);
    chk("t6 trng_en", en_a, 1'b0);
    chk("t6 rd_en", rd_en_a, 1'b0);
    chk("t6 addr", addr_a, 3'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    x = {32'h0badf00d, 192'd0, 32'h00c0ffee};
    bursts_a.push_back(x);
    sb_a.push_back('{1'b0, x, 4'd0});
    run_a("t7", 200, lat, enp);
    chk("t7 latency", lat, 33);

    chk("protocol violations", viol, 0);
    chk("scoreboard drained", sb_a.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
